t1_idle_monitor: RTL and testbench

//  Testbench-side quiescence detector that produces the `idle` input consumed by the simulation-control top.

---
 rtl/t1_idle_pkg.sv | 22 ++
 rtl/t1_idle_monitor_if.sv | 36 +++
 rtl/t1_outstanding_counter.sv | 52 +++++
 rtl/t1_idle_monitor.sv | 127 ++++++++++++
 tb/tb_t1_idle_monitor.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t1_idle_pkg.sv
//==============================================================================
// Module : t1_idle_pkg
// Brief  : Shared types and defaults for the idle / quiescence monitor.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package t1_idle_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    QUIET = 2'd2,
    IDLE  = 2'd3
  } state_e;

  localparam int DEFAULT_CNT_W        = 8;
  localparam int DEFAULT_QUIET_CYCLES = 16;

endpackage

`default_nettype wire

// File: rtl/t1_idle_monitor_if.sv
//==============================================================================
// Module : t1_idle_monitor_if
// Brief  : Per-port AXI fire strobes and core quit indication for the monitor.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface t1_idle_monitor_if #(
  parameter int NUM_PORTS = 4
);

  logic [NUM_PORTS-1:0] ar_fire;
  logic [NUM_PORTS-1:0] r_last_fire;
  logic [NUM_PORTS-1:0] aw_fire;
  logic [NUM_PORTS-1:0] b_fire;
  logic                 core_quit;

  modport master (
    output ar_fire,
    output r_last_fire,
    output aw_fire,
    output b_fire,
    output core_quit
  );

  modport slave (
    input ar_fire,
    input r_last_fire,
    input aw_fire,
    input b_fire,
    input core_quit
  );

endinterface

`default_nettype wire

// File: rtl/t1_outstanding_counter.sv
//==============================================================================
// Module : t1_outstanding_counter
// Brief  : Saturating outstanding-transaction counter with error pulses.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module t1_outstanding_counter
  import t1_idle_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic next_is_zero,
  output logic ovf,
  output logic udf
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Simultaneous inc and dec cancel; errors hold the count where it is.
  always_comb begin
    count_d = count_q;
    ovf     = 1'b0;
    udf     = 1'b0;
    if (inc && !dec) begin
      if (count_q == C_MAX) ovf = 1'b1;
      else                  count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q == '0) udf = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign is_zero      = (count_q == '0);
  assign next_is_zero = (count_d == '0);

endmodule

`default_nettype wire

// File: rtl/t1_idle_monitor.sv
//==============================================================================
// Module : t1_idle_monitor
// Brief  : Raises idle once quit is seen and all AXI ports stay drained.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module t1_idle_monitor
  import t1_idle_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter int QUIET_CYCLES = DEFAULT_QUIET_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 initFlag,
  t1_idle_monitor_if.slave     bus,
  output logic                 idle,
  output logic [NUM_PORTS-1:0] busy_ports,
  output logic                 cnt_err,
  output logic                 late_activity
);

  localparam int            QW         = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

  logic clr;
  assign clr = reset | initFlag;

  logic [NUM_PORTS-1:0] rd_zero, wr_zero, rd_next_zero, wr_next_zero;
  logic [NUM_PORTS-1:0] rd_ovf, rd_udf, wr_ovf, wr_udf;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    t1_outstanding_counter #(.CNT_W(CNT_W)) u_rd (
      .clock        (clock),
      .reset        (clr),
      .inc          (bus.ar_fire[p]),
      .dec          (bus.r_last_fire[p]),
      .is_zero      (rd_zero[p]),
      .next_is_zero (rd_next_zero[p]),
      .ovf          (rd_ovf[p]),
      .udf          (rd_udf[p])
    );
    t1_outstanding_counter #(.CNT_W(CNT_W)) u_wr (
      .clock        (clock),
      .reset        (clr),
      .inc          (bus.aw_fire[p]),
      .dec          (bus.b_fire[p]),
      .is_zero      (wr_zero[p]),
      .next_is_zero (wr_next_zero[p]),
      .ovf          (wr_ovf[p]),
      .udf          (wr_udf[p])
    );
  end

  logic any_fire;
  logic all_zero;
  assign any_fire = |{bus.ar_fire, bus.r_last_fire, bus.aw_fire, bus.b_fire};
  assign all_zero = (&rd_zero) & (&wr_zero) & ~any_fire;

  state_e               state_q, state_d;
  logic [QW-1:0]        quiet_cnt_q, quiet_cnt_d;
  logic                 idle_q, idle_d;
  logic [NUM_PORTS-1:0] busy_ports_q, busy_ports_d;
  logic                 cnt_err_q, cnt_err_d;
  logic                 late_activity_q, late_activity_d;

  always_comb begin
    state_d         = state_q;
    quiet_cnt_d     = quiet_cnt_q;
    late_activity_d = late_activity_q;
    case (state_q)
      RUN: begin
        if (bus.core_quit) state_d = DRAIN;
      end
      DRAIN: begin
        if (all_zero) begin
          state_d     = QUIET;
          quiet_cnt_d = '0;
        end
      end
      QUIET: begin
        if (!all_zero)                     state_d = DRAIN;
        else if (quiet_cnt_q == QUIET_LAST) state_d = IDLE;
        else                               quiet_cnt_d = quiet_cnt_q + 1'b1;
      end
      IDLE: begin
        // Quit is irrelevant here; only new traffic can leave IDLE.
        if (any_fire) begin
          late_activity_d = 1'b1;
          state_d         = DRAIN;
        end
      end
      default: state_d = RUN;
    endcase
    idle_d       = (state_d == IDLE);
    busy_ports_d = ~(rd_next_zero & wr_next_zero);
    cnt_err_d    = cnt_err_q | (|{rd_ovf, rd_udf, wr_ovf, wr_udf});
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q         <= RUN;
      quiet_cnt_q     <= '0;
      idle_q          <= 1'b0;
      busy_ports_q    <= '0;
      cnt_err_q       <= 1'b0;
      late_activity_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      quiet_cnt_q     <= quiet_cnt_d;
      idle_q          <= idle_d;
      busy_ports_q    <= busy_ports_d;
      cnt_err_q       <= cnt_err_d;
      late_activity_q <= late_activity_d;
    end
  end

  assign idle          = idle_q;
  assign busy_ports    = busy_ports_q;
  assign cnt_err       = cnt_err_q;
  assign late_activity = late_activity_q;

endmodule

`default_nettype wire

// File: tb/tb_t1_idle_monitor.sv
//==============================================================================
// Module : tb_t1_idle_monitor
// Brief  : Directed self-checking bench for t1_idle_monitor.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_t1_idle_monitor;

  localparam int NP = 4;
  localparam int Q  = 16;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic initFlag = 1'b0;

  t1_idle_monitor_if #(.NUM_PORTS(NP)) bus  ();
  t1_idle_monitor_if #(.NUM_PORTS(NP)) bus2 ();

  logic          idle, cnt_err, late_activity;
  logic [NP-1:0] busy_ports;
  logic          idle2, cnt_err2, late_activity2;
  logic [NP-1:0] busy_ports2;

  int total = 0;
  int bad   = 0;

  t1_idle_monitor #(.NUM_PORTS(NP), .CNT_W(8), .QUIET_CYCLES(Q)) dut (
    .clock         (clock),
    .reset         (reset),
    .initFlag      (initFlag),
    .bus           (bus.slave),
    .idle          (idle),
    .busy_ports    (busy_ports),
    .cnt_err       (cnt_err),
    .late_activity (late_activity)
  );

  // Narrow counters and the minimum quiet window.
  t1_idle_monitor #(.NUM_PORTS(NP), .CNT_W(2), .QUIET_CYCLES(1)) dut2 (
    .clock         (clock),
    .reset         (reset),
    .initFlag      (initFlag),
    .bus           (bus2.slave),
    .idle          (idle2),
    .busy_ports    (busy_ports2),
    .cnt_err       (cnt_err2),
    .late_activity (late_activity2)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ar_fire      = '0;
    bus.r_last_fire  = '0;
    bus.aw_fire      = '0;
    bus.b_fire       = '0;
    bus.core_quit    = 1'b0;
    bus2.ar_fire     = '0;
    bus2.r_last_fire = '0;
    bus2.aw_fire     = '0;
    bus2.b_fire      = '0;
    bus2.core_quit   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({idle, busy_ports, cnt_err, late_activity} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {idle, busy_ports, cnt_err, late_activity});
    end
    total++;
    if ({idle2, busy_ports2, cnt_err2, late_activity2} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs_dut2 got=%b want=0", {idle2, busy_ports2, cnt_err2, late_activity2});
    end
    bus.aw_fire = 4'b0001;
    step();
    bus.aw_fire = '0;
    total++;
    if (busy_ports !== 4'b0001) begin
      bad++;
      $display("FAIL busy_after_aw got=%b want=0001", busy_ports);
    end
    initFlag = 1'b1;
    step();
    initFlag = 1'b0;
    total++;
    if (busy_ports !== 4'b0000) begin
      bad++;
      $display("FAIL initflag_clears got=%b want=0000", busy_ports);
    end
  endtask

  task automatic test_quit_no_traffic();
    do_reset();
    repeat (4) step();
    bus.core_quit = 1'b1;
    step();
    bus.core_quit = 1'b0;
    for (int i = 1; i <= Q; i++) begin
      step();
      if (i == Q) begin
        total++;
        if (idle !== 1'b0) begin
          bad++;
          $display("FAIL quit_idle_early got=%b want=0", idle);
        end
      end
    end
    step();
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL quit_idle_rise got=%b want=1", idle);
    end
    repeat (3) step();
    total++;
    if ({idle, cnt_err, late_activity} !== 3'b100) begin
      bad++;
      $display("FAIL quit_idle_hold got=%b want=100", {idle, cnt_err, late_activity});
    end
  endtask

  task automatic test_read_drain();
    do_reset();
    bus.ar_fire = 4'b0010;
    repeat (3) step();
    bus.ar_fire = '0;
    total++;
    if (busy_ports !== 4'b0010) begin
      bad++;
      $display("FAIL rd_busy got=%b want=0010", busy_ports);
    end
    bus.core_quit = 1'b1;
    step();
    bus.core_quit = 1'b0;
    repeat (9) step();
    for (int k = 0; k < 3; k++) begin
      bus.r_last_fire = 4'b0010;
      step();
      bus.r_last_fire = '0;
      if (k == 1) begin
        total++;
        if (busy_ports !== 4'b0010) begin
          bad++;
          $display("FAIL rd_busy_before_last got=%b want=0010", busy_ports);
        end
      end
    end
    total++;
    if (busy_ports !== 4'b0000 || idle !== 1'b0) begin
      bad++;
      $display("FAIL rd_drained got=%b/%b want=0000/0", busy_ports, idle);
    end
    repeat (Q) step();
    total++;
    if (idle !== 1'b0) begin
      bad++;
      $display("FAIL rd_idle_early got=%b want=0", idle);
    end
    step();
    total++;
    if (idle !== 1'b1 || cnt_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_idle_rise got=%b/%b want=1/0", idle, cnt_err);
    end
  endtask

  task automatic test_quiet_restart();
    do_reset();
    bus.core_quit = 1'b1;
    step();
    bus.core_quit = 1'b0;
    repeat (11) step();
    bus.aw_fire = 4'b0001;
    step();
    bus.aw_fire = '0;
    total++;
    if (busy_ports !== 4'b0001 || idle !== 1'b0) begin
      bad++;
      $display("FAIL qr_aw got=%b/%b want=0001/0", busy_ports, idle);
    end
    repeat (3) step();
    bus.b_fire = 4'b0001;
    step();
    bus.b_fire = '0;
    total++;
    if (busy_ports !== 4'b0000) begin
      bad++;
      $display("FAIL qr_b got=%b want=0000", busy_ports);
    end
    repeat (Q) step();
    total++;
    if (idle !== 1'b0) begin
      bad++;
      $display("FAIL qr_idle_early got=%b want=0", idle);
    end
    step();
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL qr_idle_rise got=%b want=1", idle);
    end
  endtask

  task automatic test_counter_edges();
    do_reset();
    bus.ar_fire     = 4'b0100;
    bus.r_last_fire = 4'b0100;
    step();
    clear_inputs();
    total++;
    if (busy_ports !== 4'b0000 || cnt_err !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle got=%b/%b want=0000/0", busy_ports, cnt_err);
    end
    bus.b_fire = 4'b1000;
    step();
    bus.b_fire = '0;
    total++;
    if (busy_ports !== 4'b0000 || cnt_err !== 1'b1) begin
      bad++;
      $display("FAIL underflow got=%b/%b want=0000/1", busy_ports, cnt_err);
    end
    bus.aw_fire = 4'b1000;
    step();
    bus.aw_fire = '0;
    bus.b_fire  = 4'b1000;
    step();
    bus.b_fire  = '0;
    total++;
    if (busy_ports !== 4'b0000 || cnt_err !== 1'b1) begin
      bad++;
      $display("FAIL underflow_held_zero got=%b/%b want=0000/1", busy_ports, cnt_err);
    end
  endtask

  task automatic test_saturate_and_q1();
    do_reset();
    bus2.aw_fire = 4'b0001;
    repeat (3) step();
    total++;
    if (cnt_err2 !== 1'b0) begin
      bad++;
      $display("FAIL sat_no_err_at_3 got=%b want=0", cnt_err2);
    end
    step();
    bus2.aw_fire = '0;
    total++;
    if (cnt_err2 !== 1'b1 || busy_ports2 !== 4'b0001) begin
      bad++;
      $display("FAIL sat_overflow got=%b/%b want=1/0001", cnt_err2, busy_ports2);
    end
    bus2.b_fire = 4'b0001;
    repeat (2) step();
    total++;
    if (busy_ports2 !== 4'b0001) begin
      bad++;
      $display("FAIL sat_two_b got=%b want=0001", busy_ports2);
    end
    step();
    bus2.b_fire = '0;
    total++;
    if (busy_ports2 !== 4'b0000 || cnt_err2 !== 1'b1) begin
      bad++;
      $display("FAIL sat_three_b got=%b/%b want=0000/1", busy_ports2, cnt_err2);
    end
    bus2.core_quit = 1'b1;
    step();
    bus2.core_quit = 1'b0;
    step();
    total++;
    if (idle2 !== 1'b0) begin
      bad++;
      $display("FAIL q1_idle_early got=%b want=0", idle2);
    end
    step();
    total++;
    if (idle2 !== 1'b1) begin
      bad++;
      $display("FAIL q1_idle_rise got=%b want=1", idle2);
    end
  endtask

  task automatic test_late_activity();
    do_reset();
    bus.core_quit = 1'b1;
    step();
    bus.core_quit = 1'b0;
    repeat (Q + 1) step();
    total++;
    if (idle !== 1'b1 || late_activity !== 1'b0) begin
      bad++;
      $display("FAIL late_pre got=%b/%b want=1/0", idle, late_activity);
    end
    bus.ar_fire = 4'b0001;
    step();
    bus.ar_fire = '0;
    total++;
    if ({idle, late_activity, busy_ports} !== 6'b01_0001) begin
      bad++;
      $display("FAIL late_post got=%b want=010001", {idle, late_activity, busy_ports});
    end
    do_reset();
    total++;
    if ({idle, busy_ports, cnt_err, late_activity} !== 7'b0) begin
      bad++;
      $display("FAIL late_reset got=%b want=0", {idle, busy_ports, cnt_err, late_activity});
    end
    bus.core_quit = 1'b1;
    step();
    bus.core_quit = 1'b0;
    repeat (Q) step();
    total++;
    if (idle !== 1'b0) begin
      bad++;
      $display("FAIL late_requit_early got=%b want=0", idle);
    end
    step();
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL late_requit_rise got=%b want=1", idle);
    end
  endtask

  initial begin
    clear_inputs();
    repeat (2) step();
    test_reset();
    test_quit_no_traffic();
    test_read_drain();
    test_quiet_restart();
    test_counter_edges();
    test_saturate_and_q1();
    test_late_activity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
